// File: rtl/trdb_filter_cfg.sv
// APB register block for the trace encoder's instruction-qualification filter.
// Software writes a shadow copy; a commit copies it to the active copy at an encoder-granted packet boundary.
module trdb_filter_cfg #(
    parameter int XLEN      = 32,
    parameter int CAUSE_LEN = 5,
    parameter int APB_AW    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [APB_AW-1:0]    paddr_i,
    input  logic [XLEN-1:0]      pwdata_i,
    output logic [XLEN-1:0]      prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,

    input  logic                 commit_ok_i,
    output logic                 commit_pending_o,

    output logic                 cause_filter_o,
    output logic                 cause_range_mode_o,
    output logic                 cause_equal_mode_o,
    output logic                 tvec_filter_o,
    output logic                 tvec_range_mode_o,
    output logic                 tvec_equal_mode_o,
    output logic                 tval_filter_o,
    output logic                 tval_range_mode_o,
    output logic                 tval_equal_mode_o,
    output logic                 priv_lvl_filter_o,
    output logic                 priv_lvl_range_mode_o,
    output logic                 priv_lvl_equal_mode_o,
    output logic                 iaddr_filter_o,
    output logic                 iaddr_range_mode_o,
    output logic                 iaddr_equal_mode_o,

    output logic [CAUSE_LEN-1:0] upper_cause_o,
    output logic [CAUSE_LEN-1:0] lower_cause_o,
    output logic [CAUSE_LEN-1:0] match_cause_o,
    output logic [XLEN-1:2]      upper_tvec_o,
    output logic [XLEN-1:2]      lower_tvec_o,
    output logic [XLEN-1:2]      match_tvec_o,
    output logic [XLEN-1:0]      upper_tval_o,
    output logic [XLEN-1:0]      lower_tval_o,
    output logic [XLEN-1:0]      match_tval_o,
    output logic [XLEN-1:2]      upper_priv_lvl_o,
    output logic [XLEN-1:2]      lower_priv_lvl_o,
    output logic [XLEN-1:2]      match_priv_lvl_o,
    output logic [XLEN-1:2]      upper_iaddr_o,
    output logic [XLEN-1:2]      lower_iaddr_o,
    output logic [XLEN-1:2]      match_iaddr_o
);

    localparam int WORD_W = APB_AW - 2;
    localparam logic [WORD_W-1:0] WORD_COMMIT = WORD_W'(20);
    localparam logic [WORD_W-1:0] WORD_STATUS = WORD_W'(21);

    // ctrl[f] = {equal, range, enable}; f: cause, tvec, tval, priv_lvl, iaddr
    typedef struct packed {
        logic [4:0][2:0]      ctrl;
        logic [CAUSE_LEN-1:0] upper_cause, lower_cause, match_cause;
        logic [XLEN-1:2]      upper_tvec,  lower_tvec,  match_tvec;
        logic [XLEN-1:0]      upper_tval,  lower_tval,  match_tval;
        logic [XLEN-1:2]      upper_priv,  lower_priv,  match_priv;
        logic [XLEN-1:2]      upper_iaddr, lower_iaddr, match_iaddr;
    } cfg_t;

    cfg_t              r_shadow;
    cfg_t              r_active;
    cfg_t              w_shadow_nxt;
    logic              r_pending;
    logic [7:0]        r_count;

    logic [WORD_W-1:0] w_word;
    logic              w_aligned;
    logic              w_is_field;
    logic              w_is_commit;
    logic              w_is_status;
    logic              w_access;
    logic              w_err;
    logic              w_stall;
    logic              w_wr;
    logic              w_commit_req;
    logic              w_xfer;
    logic [XLEN-1:0]   w_rdata;

    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:2] v);
        return {v, 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] ext_c(input logic [CAUSE_LEN-1:0] v);
        return {{(XLEN-CAUSE_LEN){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] ext_ctrl(input logic [2:0] v);
        return {{(XLEN-3){1'b0}}, v};
    endfunction

    assign w_word      = paddr_i[APB_AW-1:2];
    assign w_aligned   = (paddr_i[1:0] == 2'b00);
    assign w_is_field  = (w_word < WORD_COMMIT);
    assign w_is_commit = (w_word == WORD_COMMIT);
    assign w_is_status = (w_word == WORD_STATUS);
    assign w_access    = psel_i & penable_i;

    assign w_err = w_access & (~w_aligned
                               | ~(w_is_field | w_is_commit | w_is_status)
                               | (pwrite_i & w_is_status));

    // A second commit cannot be queued behind an unapplied one, so the bus waits instead.
    assign w_stall      = w_access & pwrite_i & w_aligned & w_is_commit & r_pending;
    assign w_wr         = w_access & pwrite_i & ~w_err & ~w_stall;
    assign w_commit_req = w_wr & w_is_commit & pwdata_i[0];
    assign w_xfer       = r_pending & commit_ok_i;

    assign pready_o         = ~w_stall;
    assign pslverr_o        = w_err;
    assign prdata_o         = w_rdata;
    assign commit_pending_o = r_pending;

    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wr && w_is_field) begin
            case (w_word[4:0])
                5'd0:  w_shadow_nxt.ctrl[0]     = pwdata_i[2:0];
                5'd1:  w_shadow_nxt.upper_cause = pwdata_i[CAUSE_LEN-1:0];
                5'd2:  w_shadow_nxt.lower_cause = pwdata_i[CAUSE_LEN-1:0];
                5'd3:  w_shadow_nxt.match_cause = pwdata_i[CAUSE_LEN-1:0];
                5'd4:  w_shadow_nxt.ctrl[1]     = pwdata_i[2:0];
                5'd5:  w_shadow_nxt.upper_tvec  = pwdata_i[XLEN-1:2];
                5'd6:  w_shadow_nxt.lower_tvec  = pwdata_i[XLEN-1:2];
                5'd7:  w_shadow_nxt.match_tvec  = pwdata_i[XLEN-1:2];
                5'd8:  w_shadow_nxt.ctrl[2]     = pwdata_i[2:0];
                5'd9:  w_shadow_nxt.upper_tval  = pwdata_i;
                5'd10: w_shadow_nxt.lower_tval  = pwdata_i;
                5'd11: w_shadow_nxt.match_tval  = pwdata_i;
                5'd12: w_shadow_nxt.ctrl[3]     = pwdata_i[2:0];
                5'd13: w_shadow_nxt.upper_priv  = pwdata_i[XLEN-1:2];
                5'd14: w_shadow_nxt.lower_priv  = pwdata_i[XLEN-1:2];
                5'd15: w_shadow_nxt.match_priv  = pwdata_i[XLEN-1:2];
                5'd16: w_shadow_nxt.ctrl[4]     = pwdata_i[2:0];
                5'd17: w_shadow_nxt.upper_iaddr = pwdata_i[XLEN-1:2];
                5'd18: w_shadow_nxt.lower_iaddr = pwdata_i[XLEN-1:2];
                5'd19: w_shadow_nxt.match_iaddr = pwdata_i[XLEN-1:2];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_access && !pwrite_i && !w_err) begin
            if (w_is_status) begin
                w_rdata = {{(XLEN-16){1'b0}}, r_count, 7'b0, r_pending};
            end else if (w_is_field) begin
                case (w_word[4:0])
                    5'd0:  w_rdata = ext_ctrl(r_shadow.ctrl[0]);
                    5'd1:  w_rdata = ext_c(r_shadow.upper_cause);
                    5'd2:  w_rdata = ext_c(r_shadow.lower_cause);
                    5'd3:  w_rdata = ext_c(r_shadow.match_cause);
                    5'd4:  w_rdata = ext_ctrl(r_shadow.ctrl[1]);
                    5'd5:  w_rdata = ext_w(r_shadow.upper_tvec);
                    5'd6:  w_rdata = ext_w(r_shadow.lower_tvec);
                    5'd7:  w_rdata = ext_w(r_shadow.match_tvec);
                    5'd8:  w_rdata = ext_ctrl(r_shadow.ctrl[2]);
                    5'd9:  w_rdata = r_shadow.upper_tval;
                    5'd10: w_rdata = r_shadow.lower_tval;
                    5'd11: w_rdata = r_shadow.match_tval;
                    5'd12: w_rdata = ext_ctrl(r_shadow.ctrl[3]);
                    5'd13: w_rdata = ext_w(r_shadow.upper_priv);
                    5'd14: w_rdata = ext_w(r_shadow.lower_priv);
                    5'd15: w_rdata = ext_w(r_shadow.match_priv);
                    5'd16: w_rdata = ext_ctrl(r_shadow.ctrl[4]);
                    5'd17: w_rdata = ext_w(r_shadow.upper_iaddr);
                    5'd18: w_rdata = ext_w(r_shadow.lower_iaddr);
                    5'd19: w_rdata = ext_w(r_shadow.match_iaddr);
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    // NOTE: non-blocking assignments let the active copy capture the pre-write shadow on a shared edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_xfer) begin
                r_active <= r_shadow;
                r_count  <= r_count + 8'd1;
            end
            if (w_commit_req) begin
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cause_filter_o        = r_active.ctrl[0][0];
    assign cause_range_mode_o    = r_active.ctrl[0][1];
    assign cause_equal_mode_o    = r_active.ctrl[0][2];
    assign tvec_filter_o         = r_active.ctrl[1][0];
    assign tvec_range_mode_o     = r_active.ctrl[1][1];
    assign tvec_equal_mode_o     = r_active.ctrl[1][2];
    assign tval_filter_o         = r_active.ctrl[2][0];
    assign tval_range_mode_o     = r_active.ctrl[2][1];
    assign tval_equal_mode_o     = r_active.ctrl[2][2];
    assign priv_lvl_filter_o     = r_active.ctrl[3][0];
    assign priv_lvl_range_mode_o = r_active.ctrl[3][1];
    assign priv_lvl_equal_mode_o = r_active.ctrl[3][2];
    assign iaddr_filter_o        = r_active.ctrl[4][0];
    assign iaddr_range_mode_o    = r_active.ctrl[4][1];
    assign iaddr_equal_mode_o    = r_active.ctrl[4][2];

    assign upper_cause_o    = r_active.upper_cause;
    assign lower_cause_o    = r_active.lower_cause;
    assign match_cause_o    = r_active.match_cause;
    assign upper_tvec_o     = r_active.upper_tvec;
    assign lower_tvec_o     = r_active.lower_tvec;
    assign match_tvec_o     = r_active.match_tvec;
    assign upper_tval_o     = r_active.upper_tval;
    assign lower_tval_o     = r_active.lower_tval;
    assign match_tval_o     = r_active.match_tval;
    assign upper_priv_lvl_o = r_active.upper_priv;
    assign lower_priv_lvl_o = r_active.lower_priv;
    assign match_priv_lvl_o = r_active.match_priv;
    assign upper_iaddr_o    = r_active.upper_iaddr;
    assign lower_iaddr_o    = r_active.lower_iaddr;
    assign match_iaddr_o    = r_active.match_iaddr;

endmodule

// File: tb/tb_trdb_filter_cfg.sv
// Directed bench for trdb_filter_cfg: register map table, then commit, stall, same-edge, wrap and reset sequences.
module tb_trdb_filter_cfg;

    logic        clk, rst_ni;
    logic        psel, penable, pwrite, commit_ok;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, pending;

    logic        cf, cr, ce, vf, vr, ve, tf, tr, te, pf, pr, pe, af, ar, ae;
    logic [4:0]  up_c, lo_c, ma_c;
    logic [29:0] up_v, lo_v, ma_v, up_p, lo_p, ma_p, up_a, lo_a, ma_a;
    logic [31:0] up_t, lo_t, ma_t;

    logic        all_zero;
    assign all_zero = ~|{cf, cr, ce, vf, vr, ve, tf, tr, te, pf, pr, pe, af, ar, ae,
                         up_c, lo_c, ma_c, up_v, lo_v, ma_v, up_t, lo_t, ma_t,
                         up_p, lo_p, ma_p, up_a, lo_a, ma_a};

    trdb_filter_cfg dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr),
        .commit_ok_i(commit_ok), .commit_pending_o(pending),
        .cause_filter_o(cf), .cause_range_mode_o(cr), .cause_equal_mode_o(ce),
        .tvec_filter_o(vf), .tvec_range_mode_o(vr), .tvec_equal_mode_o(ve),
        .tval_filter_o(tf), .tval_range_mode_o(tr), .tval_equal_mode_o(te),
        .priv_lvl_filter_o(pf), .priv_lvl_range_mode_o(pr), .priv_lvl_equal_mode_o(pe),
        .iaddr_filter_o(af), .iaddr_range_mode_o(ar), .iaddr_equal_mode_o(ae),
        .upper_cause_o(up_c), .lower_cause_o(lo_c), .match_cause_o(ma_c),
        .upper_tvec_o(up_v), .lower_tvec_o(lo_v), .match_tvec_o(ma_v),
        .upper_tval_o(up_t), .lower_tval_o(lo_t), .match_tval_o(ma_t),
        .upper_priv_lvl_o(up_p), .lower_priv_lvl_o(lo_p), .match_priv_lvl_o(ma_p),
        .upper_iaddr_o(up_a), .lower_iaddr_o(lo_a), .match_iaddr_o(ma_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts and ends at 1 time unit after a rising edge; the access completes on the last edge.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        int waits;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        check("apb_wait_bound", 64'(waits >= 100), 64'd0);
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; commit_ok = 0;
        rst_ni = 1'b0;
        #12;
        check("rst_pready", 64'(pready), 64'd1);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_outputs_zero", 64'(all_zero), 64'd1);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a <= 8'h54; a += 4) begin
            apb(1'b0, 8'(a), 32'h0, rd, err);
            check($sformatf("reset_read_%02h", a), {31'(err), rd}, 64'd0);
        end

        vecs.push_back('{1'b1, 8'h44, 32'h8000_0003, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h44, 32'h0, 32'h8000_0000, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 32'h0, 32'h0000_0007, 1'b0});
        vecs.push_back('{1'b1, 8'h0C, 32'hFFFF_FFE3, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'h0000_0003, 1'b0});
        vecs.push_back('{1'b1, 8'h24, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h24, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 8'h18, 32'h1234_5677, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h18, 32'h0, 32'h1234_5674, 1'b0});
        vecs.push_back('{1'b1, 8'h38, 32'h0000_000B, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h38, 32'h0, 32'h0000_0008, 1'b0});
        vecs.push_back('{1'b1, 8'h40, 32'h0000_0006, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h40, 32'h0, 32'h0000_0006, 1'b0});
        vecs.push_back('{1'b1, 8'h50, 32'h0000_0000, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h50, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h54, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 8'h58, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 8'h02, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 8'h54, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 8'h46, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 8'h58, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 8'hFC, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 8'h44, 32'h0, 32'h8000_0000, 1'b0});
        vecs.push_back('{1'b0, 8'h54, 32'h0, 32'h0, 1'b0});

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            check($sformatf("vec%0d_rdata@%02h", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_pslverr@%02h", i, vecs[i].addr), 64'(err), 64'(vecs[i].exp_err));
        end
        check("active_untouched_by_shadow", 64'(all_zero), 64'd1);

        // First commit, held off by the encoder for five cycles.
        apb(1'b1, 8'h50, 32'h1, rd, err);
        for (int c = 0; c < 5; c++) begin
            check("held_pending", 64'(pending), 64'd1);
            check("held_upper_iaddr", 64'(up_a), 64'd0);
            @(posedge clk); #1;
        end
        commit_ok = 1'b1;
        @(posedge clk); #1;
        commit_ok = 1'b0;
        check("c1_pending", 64'(pending), 64'd0);
        check("c1_upper_iaddr", 64'(up_a), 64'h2000_0000);
        check("c1_cause_ctrl", 64'({ce, cr, cf}), 64'd7);
        check("c1_iaddr_ctrl", 64'({ae, ar, af}), 64'd6);
        check("c1_match_cause", 64'(ma_c), 64'd3);
        check("c1_upper_tval", 64'(up_t), 64'hDEAD_BEEF);
        check("c1_lower_tvec", 64'(lo_v), 64'h048D_159D);
        check("c1_lower_priv", 64'(lo_p), 64'd2);
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("c1_status", 64'(rd), 64'h0100);

        // Commit written while another is pending stalls until the transfer.
        apb(1'b1, 8'h50, 32'h1, rd, err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h50; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_pready_low", 64'(pready), 64'd0);
        end
        @(posedge clk); #1;
        commit_ok = 1'b1;
        @(negedge clk);
        check("stall_pready_low_ok_cycle", 64'(pready), 64'd0);
        @(posedge clk); #1;
        commit_ok = 1'b0;
        @(negedge clk);
        check("stall_pready_released", 64'(pready), 64'd1);
        check("stall_pending_cleared", 64'(pending), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("stall_pending_reset", 64'(pending), 64'd1);
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("stall_status", 64'(rd), 64'h0201);

        // Shadow write on the transfer edge: active keeps the old value.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5;
        @(posedge clk); #1;
        penable = 1'b1;
        commit_ok = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        commit_ok = 1'b0;
        check("same_edge_match_cause", 64'(ma_c), 64'd3);
        check("same_edge_pending", 64'(pending), 64'd0);
        apb(1'b0, 8'h0C, 32'h0, rd, err);
        check("same_edge_shadow", 64'(rd), 64'd5);
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("same_edge_status", 64'(rd), 64'h0300);

        // commit_ok during the accepting cycle is ignored; transfer lands one edge later.
        commit_ok = 1'b1;
        apb(1'b1, 8'h50, 32'h1, rd, err);
        check("n_pending", 64'(pending), 64'd1);
        check("n_match_cause", 64'(ma_c), 64'd3);
        @(posedge clk); #1;
        check("n1_pending", 64'(pending), 64'd0);
        check("n1_match_cause", 64'(ma_c), 64'd5);

        for (int k = 0; k < 251; k++) begin
            apb(1'b1, 8'h50, 32'h1, rd, err);
            @(posedge clk); #1;
        end
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("count_ff", 64'(rd), 64'hFF00);
        apb(1'b1, 8'h50, 32'h1, rd, err);
        @(posedge clk); #1;
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("count_wrap", 64'(rd), 64'h0000);
        commit_ok = 1'b0;

        // Reset in the middle of a stalled commit.
        apb(1'b1, 8'h50, 32'h1, rd, err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h50; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("pre_rst_stall", 64'(pready), 64'd0);
        #1 rst_ni = 1'b0;
        #1;
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_pready", 64'(pready), 64'd1);
        check("mid_rst_outputs_zero", 64'(all_zero), 64'd1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        apb(1'b0, 8'h44, 32'h0, rd, err);
        check("post_rst_shadow", 64'(rd), 64'd0);
        apb(1'b0, 8'h54, 32'h0, rd, err);
        check("post_rst_status", 64'(rd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
